// File: rtl/fpga_channel_pkg.sv
// Shared definitions for the program's I/O channels.
// Provides the default channel word width, the default out-buffer depth, the channel word type
// and the drain-state enumeration used by the out-channel drain.
package fpga_channel_pkg;

  localparam int unsigned DefaultElementWidth = 12;
  localparam int unsigned DefaultNOut         = 16;

  typedef logic [DefaultElementWidth-1:0] channel_word_t;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DONE
  } drain_state_e;

endpackage

// File: rtl/out_channel_drain_if.sv
// Handshake bundle for the out channel.
// Core side: out_valid/out_data/finished in, out_ready back.
// Host side: tx_valid/tx_data/tx_last out, tx_ready back.
// Modports:
//   slave  - the drain block (consumes core words, produces host words)
//   master - the environment (core + host) driving the drain
interface out_channel_drain_if
  import fpga_channel_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DefaultElementWidth
);

  logic                          out_valid;
  logic [MemoryElementWidth-1:0] out_data;
  logic                          out_ready;
  logic                          finished;
  logic                          tx_valid;
  logic [MemoryElementWidth-1:0] tx_data;
  logic                          tx_last;
  logic                          tx_ready;

  modport slave (
    input  out_valid,
    input  out_data,
    input  finished,
    input  tx_ready,
    output out_ready,
    output tx_valid,
    output tx_data,
    output tx_last
  );

  modport master (
    output out_valid,
    output out_data,
    output finished,
    output tx_ready,
    input  out_ready,
    input  tx_valid,
    input  tx_data,
    input  tx_last
  );

endinterface

// File: rtl/out_channel_ram.sv
// Depth x Width storage array with one clocked write port and one asynchronous read port.
// Contents are never reset; callers track validity with their own pointers.
// Ports:
//   clock - write clock
//   we    - write enable
//   waddr - write address (must be < Depth)
//   wdata - write data
//   raddr - read address (must be < Depth)
//   rdata - combinational read data at raddr
module out_channel_ram
  import fpga_channel_pkg::*;
#(
  parameter int unsigned Width     = DefaultElementWidth,
  parameter int unsigned Depth     = DefaultNOut,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [Width-1:0]     wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [Width-1:0]     rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_channel_drain.sv
// Receiving end of the program's out channel. Buffers words emitted by the core in a circular
// store and streams them to the host over a valid/ready link with first-word fall-through.
// Once the core reports finished, the buffer is flushed and drained is raised when empty.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   chan         - out-channel handshake bundle (slave side)
//   count        - words currently buffered
//   total        - words accepted since reset (wraps modulo 2^32)
//   overflow     - sticky: a word was dropped (buffer full, or write after finished)
//   drained      - program finished and every buffered word delivered
module out_channel_drain
  import fpga_channel_pkg::*;
#(
  parameter int unsigned MemoryElementWidth = DefaultElementWidth,
  parameter int unsigned NOut               = DefaultNOut,
  parameter int unsigned CountWidth         = $clog2(NOut + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  out_channel_drain_if.slave    chan,
  output logic [CountWidth-1:0] count,
  output logic [31:0]           total,
  output logic                  overflow,
  output logic                  drained
);

  localparam int unsigned PtrWidth = $clog2(NOut);
  localparam logic [PtrWidth-1:0]   LastPtr = PtrWidth'(NOut - 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(NOut);

  logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountWidth-1:0] count_q, count_d;
  logic [31:0]           total_q;
  logic                  overflow_q;
  logic                  drained_q;
  drain_state_e          state_q;

  logic accept;
  logic deliver;
  logic drop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // Ready depends only on registered state: a full buffer refuses a write even if a word
  // leaves in the same cycle.
  assign chan.out_ready = (count_q < FullCount) && (state_q == RUN);
  assign chan.tx_valid  = (count_q != '0);
  assign chan.tx_last   = chan.tx_valid && (state_q == FLUSH) && (count_q == CountWidth'(1));

  assign accept  = chan.out_valid && chan.out_ready;
  assign deliver = chan.tx_valid && chan.tx_ready;
  assign drop    = chan.out_valid && !chan.out_ready;

  out_channel_ram #(
    .Width (MemoryElementWidth),
    .Depth (NOut),
    .AddrWidth (PtrWidth)
  ) u_ram (
    .clock (clock),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (chan.out_data),
    .raddr (rd_ptr_q),
    .rdata (chan.tx_data)
  );

  always_comb begin
    count_d = count_q;
    case ({accept, deliver})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      total_q  <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        total_q  <= total_q + 32'd1;
      end
      if (deliver) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_d;
    end
  end

  // Drain state machine with registered drained/overflow flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      overflow_q <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        RUN: begin
          // A write in the same cycle as finished is still accepted above.
          if (chan.finished) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (count_d == '0) begin
            state_q   <= DONE;
            drained_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign count    = count_q;
  assign total    = total_q;
  assign overflow = overflow_q;
  assign drained  = drained_q;

endmodule

// File: tb/tb_out_channel_drain.sv
module tb_out_channel_drain;

  logic        clock;
  logic        reset;
  logic        out_valid;
  logic [11:0] out_data;
  logic        finished;
  logic        tx_ready;

  logic [2:0]  count4, count5;
  logic [31:0] total4, total5;
  logic        overflow4, overflow5, drained4, drained5;

  int checks;
  int failures;

  out_channel_drain_if #(.MemoryElementWidth(12)) if4 ();
  out_channel_drain_if #(.MemoryElementWidth(12)) if5 ();

  assign if4.out_valid = out_valid;
  assign if4.out_data  = out_data;
  assign if4.finished  = finished;
  assign if4.tx_ready  = tx_ready;
  assign if5.out_valid = out_valid;
  assign if5.out_data  = out_data;
  assign if5.finished  = finished;
  assign if5.tx_ready  = tx_ready;

  out_channel_drain #(.MemoryElementWidth(12), .NOut(4)) u_dut4 (
    .clock    (clock),
    .reset    (reset),
    .chan     (if4),
    .count    (count4),
    .total    (total4),
    .overflow (overflow4),
    .drained  (drained4)
  );

  out_channel_drain #(.MemoryElementWidth(12), .NOut(5)) u_dut5 (
    .clock    (clock),
    .reset    (reset),
    .chan     (if5),
    .count    (count5),
    .total    (total5),
    .overflow (overflow5),
    .drained  (drained5)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural model: a plain FIFO queue per instance ----------------
  logic [11:0] q0[$];
  logic [11:0] q1[$];
  int          cap[2] = '{4, 5};
  int          mst[2];   // 0: still running, 1: finished seen, 2: drained
  logic [31:0] mtot[2];
  bit          movf[2];

  function automatic int msize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [11:0] mfront(input int i);
    if (msize(i) == 0) return 12'h0;
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void mpush(input int i, input logic [11:0] w);
    if (i == 0) q0.push_back(w);
    else q1.push_back(w);
  endfunction

  function automatic void mpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endfunction

  function automatic void mclear();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      mst[i]  = 0;
      mtot[i] = 32'd0;
      movf[i] = 1'b0;
    end
  endfunction

  bit m_acc, m_del;
  int m_sz;

  always @(posedge clock) begin
    if (reset) begin
      mclear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_sz  = msize(i);
        m_acc = out_valid && (mst[i] == 0) && (m_sz < cap[i]);
        m_del = tx_ready && (m_sz != 0);
        if (out_valid && !m_acc) movf[i] = 1'b1;
        if (m_del) mpop(i);
        if (m_acc) begin
          mpush(i, out_data);
          mtot[i] = mtot[i] + 32'd1;
        end
        if (mst[i] == 0 && finished) mst[i] = 1;
        else if (mst[i] == 1 && msize(i) == 0) mst[i] = 2;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  logic        a_rdy, a_tv, a_tl, a_ovf, a_drn;
  logic [11:0] a_td;
  logic [2:0]  a_cnt;
  logic [31:0] a_tot;
  bit          e_tv;
  int          e_sz;

  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          a_rdy = if4.out_ready; a_tv = if4.tx_valid; a_tl = if4.tx_last; a_td = if4.tx_data;
          a_cnt = count4; a_tot = total4; a_ovf = overflow4; a_drn = drained4;
        end else begin
          a_rdy = if5.out_ready; a_tv = if5.tx_valid; a_tl = if5.tx_last; a_td = if5.tx_data;
          a_cnt = count5; a_tot = total5; a_ovf = overflow5; a_drn = drained5;
        end
        e_sz = msize(i);
        e_tv = (e_sz != 0);
        chk($sformatf("n%0d out_ready", cap[i]), 32'(a_rdy),
            32'((e_sz < cap[i]) && (mst[i] == 0)));
        chk($sformatf("n%0d tx_valid", cap[i]), 32'(a_tv), 32'(e_tv));
        chk($sformatf("n%0d tx_last", cap[i]), 32'(a_tl),
            32'(e_tv && (mst[i] == 1) && (e_sz == 1)));
        if (e_tv) chk($sformatf("n%0d tx_data", cap[i]), 32'(a_td), 32'(mfront(i)));
        chk($sformatf("n%0d count", cap[i]), 32'(a_cnt), 32'(e_sz));
        chk($sformatf("n%0d total", cap[i]), a_tot, mtot[i]);
        chk($sformatf("n%0d overflow", cap[i]), 32'(a_ovf), 32'(movf[i]));
        chk($sformatf("n%0d drained", cap[i]), 32'(a_drn), 32'(mst[i] == 2));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit ov, input logic [11:0] d, input bit fin, input bit rdy);
    out_valid = ov;
    out_data  = d;
    finished  = fin;
    tx_ready  = rdy;
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mclear();
    out_valid = 1'b0;
    finished  = 1'b0;
    tx_ready  = 1'b0;
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  int sent5;
  int iter;
  bit ov_r;
  logic [31:0] tot_snap;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    out_valid = 1'b0;
    out_data = '0;
    finished = 1'b0;
    tx_ready = 1'b0;
    mclear();
    #12;
    reset = 1'b0;
    #1;
    chk("reset out_ready", 32'(if4.out_ready), 32'd1);
    chk("reset tx_valid", 32'(if5.tx_valid), 32'd0);
    chk("reset tx_last", 32'(if5.tx_last), 32'd0);
    chk("reset count", 32'(count5), 32'd0);

    // 3, 0, 1 with finished alongside the last write.
    step(1, 12'd3, 0, 1);
    chk("seq first tx_data", 32'(if4.tx_data), 32'd3);
    step(1, 12'd0, 0, 1);
    step(1, 12'd1, 1, 1);
    chk("seq last tx_data", 32'(if5.tx_data), 32'd1);
    chk("seq tx_last", 32'(if5.tx_last), 32'd1);
    step(0, 12'd0, 0, 1);
    chk("seq drained", 32'(drained5), 32'd1);
    chk("seq total", total4, 32'd3);
    chk("seq overflow", 32'(overflow4), 32'd0);
    step(0, 12'd0, 0, 1);

    // Fill with tx_ready low: NOut=4 drops the fifth word.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 12'(10 + k), 0, 0);
    chk("full4 count", 32'(count4), 32'd4);
    chk("full4 total", total4, 32'd4);
    chk("full4 overflow", 32'(overflow4), 32'd1);
    chk("full4 out_ready", 32'(if4.out_ready), 32'd0);
    chk("full5 count", 32'(count5), 32'd5);
    step(0, 12'd0, 0, 1);
    chk("full4 second word", 32'(if4.tx_data), 32'd11);
    for (int k = 0; k < 5; k++) step(0, 12'd0, 0, 1);
    chk("full4 emptied", 32'(count4), 32'd0);
    // Second pass exercises the wrapped pointers.
    for (int k = 0; k < 3; k++) step(1, 12'(40 + k), 0, 0);
    chk("wrap head", 32'(if4.tx_data), 32'd40);
    for (int k = 0; k < 4; k++) step(0, 12'd0, 0, 1);

    // Full buffer, write and read in the same cycle: no bypass.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 12'(20 + k), 0, 0);
    step(1, 12'd25, 0, 1);
    chk("nobypass count", 32'(count5), 32'd4);
    chk("nobypass overflow", 32'(overflow5), 32'd1);
    chk("nobypass head", 32'(if5.tx_data), 32'd21);
    chk("nobypass total", total5, 32'd5);

    // Random stream of 12 words, host ready every other cycle, core respects out_ready.
    do_reset();
    sent5 = 0;
    iter = 0;
    while (sent5 < 12 && iter < 300) begin
      ov_r = ($urandom_range(0, 3) != 0) && if5.out_ready;
      if (ov_r) sent5++;
      step(ov_r, 12'($urandom_range(0, 4095)), 0, iter[0]);
      iter++;
    end
    chk("stream sent", 32'(sent5), 32'd12);
    step(0, 12'd0, 1, 1);
    iter = 0;
    while (!(drained4 && drained5) && iter < 100) begin
      step(0, 12'd0, 0, iter[0]);
      iter++;
    end
    chk("stream drained in budget", 32'(drained5 && drained4), 32'd1);
    chk("stream overflow5", 32'(overflow5), 32'd0);
    chk("stream total5", total5, 32'd12);

    // Finished with empty buffer.
    do_reset();
    step(0, 12'd0, 1, 1);
    chk("empty fin drained early", 32'(drained5), 32'd0);
    step(0, 12'd0, 0, 1);
    chk("empty fin drained", 32'(drained5), 32'd1);
    tot_snap = total5;
    step(1, 12'd7, 0, 1);
    chk("late write overflow", 32'(overflow5), 32'd1);
    chk("late write total", total5, 32'd0);
    chk("late write total unchanged", total5, tot_snap);

    // Asynchronous reset mid-stream with count=3 on the NOut=4 instance.
    do_reset();
    for (int k = 0; k < 5; k++) step(1, 12'(60 + k), 0, 0);
    step(0, 12'd0, 0, 1);
    chk("pre-reset count4", 32'(count4), 32'd3);
    chk("pre-reset overflow4", 32'(overflow4), 32'd1);
    #2;
    reset = 1'b1;
    mclear();
    #1;
    chk("async count", 32'(count4), 32'd0);
    chk("async total", total4, 32'd0);
    chk("async overflow", 32'(overflow4), 32'd0);
    chk("async tx_valid", 32'(if4.tx_valid), 32'd0);
    chk("async drained", 32'(drained4), 32'd0);
    @(negedge clock);
    #1;
    reset = 1'b0;
    step(1, 12'h05A, 0, 0);
    chk("restart head", 32'(if4.tx_data), 32'h05A);
    chk("restart count", 32'(count4), 32'd1);
    step(0, 12'd0, 0, 1);
    step(0, 12'd0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
